conv_sequencer: RTL



---
 rtl/conv_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
// ============================================================================
// Module      : conv_sequencer
// Description : Sequencer for the MSDAP convolution datapath. For each output
//               sample it walks the rj segments and coefficient memory, forms
//               data-memory addresses, and strobes the ALU accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_sequencer #(
    parameter int NUM_RJ   = 16,
    parameter int RJ_W     = 8,
    parameter int COEFF_AW = 9,
    parameter int DATA_AW  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DATA_AW-1:0]  newest_ptr,
    output logic [3:0]          rj_addr,
    input  logic [RJ_W-1:0]     rj_data,
    output logic [COEFF_AW-1:0] coeff_addr,
    input  logic [8:0]          coeff_data,
    output logic [DATA_AW-1:0]  data_addr,
    output logic                alu_clear,
    output logic                alu_acc_en,
    output logic                alu_sub,
    output logic                alu_shift,
    output logic                busy,
    output logic                conv_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RJ_RD    = 3'd1,
        S_RJ_LATCH = 3'd2,
        S_ISSUE    = 3'd3,
        S_DRAIN    = 3'd4,
        S_SHIFT    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          seg;
    logic [COEFF_AW-1:0] coeff_ptr;
    logic [RJ_W-1:0]     remaining;
    logic                drain_cnt;
    logic [DATA_AW-1:0]  n_reg;
    logic                v1;      // coeff_data valid for an issued tap
    logic                v2;      // accumulate stage valid
    logic                sign1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            seg       <= '0;
            coeff_ptr <= '0;
            remaining <= '0;
            drain_cnt <= 1'b0;
            n_reg     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            sign1     <= 1'b0;
        end else begin
            state     <= state_nxt;
            v1        <= !abort && (state == S_ISSUE);
            v2        <= !abort && v1;
            sign1     <= !abort && v1 && coeff_data[8];
            drain_cnt <= !abort && (state == S_DRAIN) && !drain_cnt;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            n_reg     <= newest_ptr;
                            seg       <= '0;
                            coeff_ptr <= '0;
                        end
                    end
                    S_RJ_LATCH: remaining <= rj_data;
                    S_ISSUE: begin
                        coeff_ptr <= coeff_ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                    S_SHIFT:    seg <= seg + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rj_addr    = '0;
        coeff_addr = '0;
        alu_clear  = 1'b0;
        alu_shift  = 1'b0;
        conv_done  = 1'b0;
        case (state)
            S_IDLE:     if (start) state_nxt = S_RJ_RD;
            S_RJ_RD: begin
                rj_addr   = seg;
                alu_clear = (seg == 4'd0);
                state_nxt = S_RJ_LATCH;
            end
            S_RJ_LATCH: state_nxt = (rj_data == '0) ? S_SHIFT : S_ISSUE;
            S_ISSUE: begin
                coeff_addr = coeff_ptr;
                if (remaining == RJ_W'(1)) state_nxt = S_DRAIN;
            end
            S_DRAIN:    if (drain_cnt) state_nxt = S_SHIFT;
            S_SHIFT: begin
                alu_shift = 1'b1;
                state_nxt = (seg == 4'(NUM_RJ - 1)) ? S_DONE : S_RJ_RD;
            end
            S_DONE: begin
                conv_done = 1'b1;
                state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Stage 1 forms the circular-buffer address x(n-k); stage 2 accumulates it.
    assign data_addr  = v1 ? (n_reg - DATA_AW'(coeff_data[7:0])) : '0;
    assign alu_acc_en = v2;
    assign alu_sub    = v2 && sign1;
    assign busy       = (state != S_IDLE);

endmodule

`default_nettype wire
